// File: rtl/mult_share_arbiter.sv
// Two-requester round-robin front end that time-shares one 3x3 multiplier.
// Results come back on a registered valid/ready port tagged with the requester id.
module three_bit_multiplier (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [5:0] p
);
    logic [5:0] pp0, pp1, pp2;

    assign pp0 = {6{b[0]}} & {3'b000, a};
    assign pp1 = {6{b[1]}} & {2'b00, a, 1'b0};
    assign pp2 = {6{b[2]}} & {1'b0, a, 2'b00};
    assign p   = pp0 + pp1 + pp2;
endmodule

module mult_share_arbiter #(
    parameter bit PRIO_RESET = 1'b0,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [2:0]       req0_a,
    input  logic [2:0]       req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [2:0]       req1_a,
    input  logic [2:0]       req1_b,
    output logic             req1_ready,
    output logic             res_valid,
    output logic [5:0]       res_product,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic       last_grant;
    logic       any_req;
    logic       winner;
    logic [2:0] op_a, op_b;
    logic       op_id;
    logic [5:0] mul_p;

    assign any_req = req0_valid | req1_valid;
    // On a tie the requester that did not win last time goes first.
    assign winner  = (req0_valid & req1_valid) ? ~last_grant : req1_valid;

    three_bit_multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (any_req) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        req0_ready = (state == IDLE) & any_req & ~winner;
        req1_ready = (state == IDLE) & any_req & winner;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a        <= 3'd0;
            op_b        <= 3'd0;
            op_id       <= 1'b0;
            last_grant  <= ~PRIO_RESET;
            res_valid   <= 1'b0;
            res_product <= 6'd0;
            res_id      <= 1'b0;
            ops_done    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        op_a       <= winner ? req1_a : req0_a;
                        op_b       <= winner ? req1_b : req0_b;
                        op_id      <= winner;
                        last_grant <= winner;
                    end
                end
                EXEC: begin
                    res_product <= mul_p;
                    res_id      <= op_id;
                    res_valid   <= 1'b1;
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ops_done  <= ops_done + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised and directed bench for mult_share_arbiter against a
// transaction-level model of accepts, results and completions.
module tb_mult_share_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
    logic [2:0] a0 = 3'd0, b0 = 3'd0, a1 = 3'd0, b1 = 3'd0;
    logic       r0, r1, res_valid, res_id, busy;
    logic [5:0] res_product;
    logic [7:0] ops_done;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // model: one in-flight transaction, its age, and the completion count
    bit m_inflight = 1'b0;
    int m_age = 0;
    int m_prod = 0;
    int m_id = 0;
    int m_cnt = 0;
    bit m_last = 1'b1;
    bit acc0 = 1'b0, acc1 = 1'b0;

    int obs_id[$];
    int obs_p[$];

    mult_share_arbiter #(.PRIO_RESET(1'b0), .CNT_W(8)) dut (
        .clk(clk), .reset(rst),
        .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
        .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
        .res_valid(res_valid), .res_product(res_product), .res_id(res_id),
        .res_ready(rr), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit w;
        acc0 = 1'b0;
        acc1 = 1'b0;
        if (rst) begin
            m_inflight = 1'b0;
            m_cnt = 0;
            m_last = 1'b1;
        end else if (!m_inflight) begin
            if (v0 || v1) begin
                w = (v0 && v1) ? !m_last : v1;
                m_inflight = 1'b1;
                m_age = 0;
                m_prod = w ? int'(a1) * int'(b1) : int'(a0) * int'(b0);
                m_id = int'(w);
                m_last = w;
                acc0 = !w;
                acc1 = w;
            end
        end else if (m_age >= 1 && rr) begin
            m_inflight = 1'b0;
            m_cnt = (m_cnt + 1) % 256;
        end else begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        bit w, any, rv;
        if (chk_en) begin
            any = v0 || v1;
            w = (v0 && v1) ? !m_last : v1;
            rv = m_inflight && m_age >= 1;
            chk("req0_ready", int'(r0), int'(!m_inflight && any && !w));
            chk("req1_ready", int'(r1), int'(!m_inflight && any && w));
            chk("ready_onehot", int'(r0 & r1), 0);
            chk("busy", int'(busy), int'(m_inflight));
            chk("res_valid", int'(res_valid), int'(rv));
            chk("ops_done", int'(ops_done), m_cnt);
            if (rv) begin
                chk("res_product", int'(res_product), m_prod);
                chk("res_id", int'(res_id), m_id);
            end
            if (res_valid && rr) begin
                obs_id.push_back(int'(res_id));
                obs_p.push_back(int'(res_product));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        bit p0, p1;
        bit req;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_product", int'(res_product), 0);
        chk("rst_ops_done", int'(ops_done), 0);
        chk("rst_busy", int'(busy), 0);

        // single op
        v0 = 1'b1; a0 = 3'd5; b0 = 3'd7; rr = 1'b1;
        tick();
        v0 = 1'b0;
        chk("single_busy", int'(busy), 1);
        chk("single_rv_early", int'(res_valid), 0);
        tick();
        chk("single_rv", int'(res_valid), 1);
        chk("single_prod", int'(res_product), 35);
        chk("single_id", int'(res_id), 0);
        tick();
        chk("single_cnt", int'(ops_done), 1);

        // tie fairness
        do_reset();
        obs_id.delete();
        obs_p.delete();
        v0 = 1'b1; a0 = 3'd7; b0 = 3'd7;
        v1 = 1'b1; a1 = 3'd3; b1 = 3'd2;
        n = 0;
        while (obs_id.size() < 4 && n < 40) begin
            tick();
            n++;
        end
        chk("tie_count", obs_id.size() >= 4 ? 4 : obs_id.size(), 4);
        if (obs_id.size() >= 4) begin
            chk("tie_id0", obs_id[0], 0); chk("tie_p0", obs_p[0], 49);
            chk("tie_id1", obs_id[1], 1); chk("tie_p1", obs_p[1], 6);
            chk("tie_id2", obs_id[2], 0); chk("tie_p2", obs_p[2], 49);
            chk("tie_id3", obs_id[3], 1); chk("tie_p3", obs_p[3], 6);
        end
        v0 = 1'b0; v1 = 1'b0;
        do_reset();

        // backpressure
        rr = 1'b0;
        v1 = 1'b1; a1 = 3'd6; b1 = 3'd4;
        tick();
        v1 = 1'b0;
        v0 = 1'b1; a0 = 3'd1; b0 = 3'd3;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rv", int'(res_valid), 1);
            chk("bp_prod", int'(res_product), 24);
            chk("bp_id", int'(res_id), 1);
            chk("bp_r0", int'(r0), 0);
            tick();
        end
        rr = 1'b1;
        tick();
        chk("bp_idle", int'(busy), 0);
        chk("bp_r0_after", int'(r0), 1);
        tick();
        v0 = 1'b0;
        tick();
        tick();

        // reset mid-op
        do_reset();
        v0 = 1'b1; a0 = 3'd7; b0 = 3'd7;
        tick();
        v0 = 1'b0;
        chk("mid_in_exec", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rv", int'(res_valid), 0);
        chk("mid_cnt", int'(ops_done), 0);
        chk("mid_busy", int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no49", int'(res_valid), 0);
        end

        // exhaustive pairs then wrap
        do_reset();
        rr = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [2:0] ta, tb;
            if (i < 64) begin
                ta = 3'(i >> 3);
                tb = 3'(i);
            end else begin
                ta = 3'($urandom_range(0, 7));
                tb = 3'($urandom_range(0, 7));
            end
            if (i % 2 == 0) begin v0 = 1'b1; a0 = ta; b0 = tb; end
            else            begin v1 = 1'b1; a1 = ta; b1 = tb; end
            n = 0;
            do begin
                tick();
                n++;
            end while (!(acc0 || acc1) && n < 20);
            if (!(acc0 || acc1)) chk("accept_timeout", 0, 1);
            v0 = 1'b0; v1 = 1'b0;
            n = 0;
            while (m_inflight && n < 20) begin
                tick();
                n++;
            end
            if (m_inflight) chk("done_timeout", 0, 1);
            if (i == 254) chk("cnt_255", int'(ops_done), 255);
        end
        chk("cnt_wrap", int'(ops_done), 0);

        // random traffic respecting requester hold rules
        p0 = 1'b0; p1 = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            rr = ($urandom_range(0, 2) != 0);
            tick();
            if (acc0) p0 = 1'b0;
            if (acc1) p1 = 1'b0;
            req = ($urandom_range(0, 2) == 0);
            if (!p0 && req) begin
                p0 = 1'b1;
                a0 = 3'($urandom_range(0, 7));
                b0 = 3'($urandom_range(0, 7));
            end
            req = ($urandom_range(0, 2) == 0);
            if (!p1 && req) begin
                p1 = 1'b1;
                a1 = 3'($urandom_range(0, 7));
                b1 = 3'($urandom_range(0, 7));
            end
            v0 = p0;
            v1 = p1;
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
